// File: rtl/imm_extend_unit_if.sv
// Request/result handshake bundle for imm_extend_unit.
// The unit connects through the slave modport, its producer/consumer through master.
interface imm_extend_unit_if #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_imm, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

  modport master (
    output in_valid, in_imm, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/imm_extend_unit.sv
// Pipelined zero/sign/upper/branch immediate extender with output register plus skid entry.
// Optional IMM_EXT_CNT_EN builds the 16-bit output-handshake counter xfer_cnt.
module imm_extend_unit #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic clk,
  input  logic rst_n,
  imm_extend_unit_if.slave bus
`ifdef IMM_EXT_CNT_EN
  ,
  output logic [15:0] xfer_cnt
`endif
);

  localparam int unsigned E = OUT_W - IN_W;

  typedef enum logic [1:0] {
    MODE_ZERO   = 2'b00,
    MODE_SIGN   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } mode_e;

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext;

  logic             or_valid;
  logic [OUT_W-1:0] or_data;
  logic [TAG_W-1:0] or_tag;
  logic             sk_valid;
  logic [OUT_W-1:0] sk_data;
  logic [TAG_W-1:0] sk_tag;
  logic             in_ready_q;

  logic accept;
  logic drain;
  logic to_or;
  logic sk_valid_nxt;

  always_comb begin
    sext = {{E{bus.in_imm[IN_W-1]}}, bus.in_imm};
    ext  = '0;
    case (mode_e'(bus.in_mode))
      MODE_ZERO:   ext = {{E{1'b0}}, bus.in_imm};
      MODE_SIGN:   ext = sext;
      MODE_UPPER:  ext = {bus.in_imm, {E{1'b0}}};
      MODE_BRANCH: ext = sext << 2;
      default:     ext = '0;
    endcase
  end

  // A new entry bypasses the skid slot whenever OR is free by the end of this cycle.
  always_comb begin
    accept = bus.in_valid && in_ready_q;
    drain  = or_valid && bus.out_ready;
    to_or  = accept && (!or_valid || (drain && !sk_valid));
    sk_valid_nxt = sk_valid;
    if (accept && !to_or) begin
      sk_valid_nxt = 1'b1;
    end else if (drain) begin
      sk_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      or_valid   <= 1'b0;
      or_data    <= '0;
      or_tag     <= '0;
      sk_valid   <= 1'b0;
      sk_data    <= '0;
      sk_tag     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      if (to_or) begin
        or_valid <= 1'b1;
        or_data  <= ext;
        or_tag   <= bus.in_tag;
      end else if (drain) begin
        or_valid <= sk_valid;
        or_data  <= sk_data;
        or_tag   <= sk_tag;
      end
      if (accept && !to_or) begin
        sk_data <= ext;
        sk_tag  <= bus.in_tag;
      end
      sk_valid   <= sk_valid_nxt;
      in_ready_q <= !sk_valid_nxt;
    end
  end

`ifdef IMM_EXT_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (drain) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = or_valid;
  assign bus.out_data  = or_data;
  assign bus.out_tag   = or_tag;

endmodule

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench for imm_extend_unit: mode table, streaming, backpressure,
// mid-operation reset, IN_W=12 instance and (with IMM_EXT_CNT_EN) counter wrap.
module tb_imm_extend_unit;

  logic clk;
  logic rst_n;

  imm_extend_unit_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) bus ();
  imm_extend_unit_if #(.IN_W(12), .OUT_W(32), .TAG_W(5)) bus12 ();

`ifdef IMM_EXT_CNT_EN
  logic [15:0] xfer_cnt;
  logic [15:0] xfer_cnt12;
`endif

  imm_extend_unit #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus)
`ifdef IMM_EXT_CNT_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  imm_extend_unit #(.IN_W(12), .OUT_W(32), .TAG_W(5)) dut12 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus12)
`ifdef IMM_EXT_CNT_EN
    ,
    .xfer_cnt (xfer_cnt12)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] model16(input logic [15:0] imm, input logic [1:0] mode);
    logic [31:0] s;
    s = {{16{imm[15]}}, imm};
    case (mode)
      2'd0:    return {16'h0000, imm};
      2'd1:    return s;
      2'd2:    return {imm, 16'h0000};
      default: return {s[29:0], 2'b00};
    endcase
  endfunction

  // Scoreboard: push on accept, pop and compare on output handshake.
  logic [36:0] sb[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_output", 1, 0);
        end else begin
          logic [36:0] e;
          e = sb.pop_front();
          check("sb_data", {32'h0, bus.out_data}, {32'h0, e[36:5]});
          check("sb_tag", {59'h0, bus.out_tag}, {59'h0, e[4:0]});
        end
      end
      if (bus.in_valid && bus.in_ready)
        sb.push_back({model16(bus.in_imm, bus.in_mode), bus.in_tag});
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[9];

  task automatic send_one(input logic [15:0] imm, input logic [1:0] mode,
                          input logic [4:0] tag, input logic [31:0] exp);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_imm   = imm;
    bus.in_mode  = mode;
    bus.in_tag   = tag;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("tbl_ready_timeout", (n < 20), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("tbl_latency_valid", bus.out_valid, 1);
    check("tbl_data", bus.out_data, exp);
    check("tbl_tag", bus.out_tag, tag);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.in_valid = 0; bus.in_imm = '0; bus.in_mode = '0; bus.in_tag = '0; bus.out_ready = 0;
    bus12.in_valid = 0; bus12.in_imm = '0; bus12.in_mode = '0; bus12.in_tag = '0; bus12.out_ready = 0;
    rst_n = 1'b0;

    tbl[0] = '{16'h8001, 2'b00, 5'd1,  32'h00008001};
    tbl[1] = '{16'h8001, 2'b01, 5'd2,  32'hFFFF8001};
    tbl[2] = '{16'h1234, 2'b10, 5'd3,  32'h12340000};
    tbl[3] = '{16'hFFFF, 2'b11, 5'd4,  32'hFFFFFFFC};
    tbl[4] = '{16'h4000, 2'b11, 5'd5,  32'h00010000};
    tbl[5] = '{16'h7FFF, 2'b01, 5'd6,  32'h00007FFF};
    tbl[6] = '{16'h8000, 2'b11, 5'd7,  32'hFFFE0000};
    tbl[7] = '{16'h0001, 2'b10, 5'd30, 32'h00010000};
    tbl[8] = '{16'hFFFF, 2'b00, 5'd31, 32'h0000FFFF};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_tag", bus.out_tag, 0);
`ifdef IMM_EXT_CNT_EN
    check("rst_xfer_cnt", xfer_cnt, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", bus.in_ready, 1);
    check("post_rst_out_valid", bus.out_valid, 0);

    // Mode table, one transfer each
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++)
      send_one(tbl[i].imm, tbl[i].mode, tbl[i].tag, tbl[i].exp);

    // Back-to-back streaming
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_imm   = 16'($urandom);
      bus.in_mode  = 2'($urandom_range(0, 3));
      bus.in_tag   = 5'(i);
      check("stream_in_ready", bus.in_ready, 1);
      @(posedge clk); #1;
      check("stream_out_valid", bus.out_valid, 1);
      check("stream_tag_order", bus.out_tag, 5'(i));
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("stream_idle", bus.out_valid, 0);

    // Backpressure: 3 offered, 2 held
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_imm = 16'hA5A5; bus.in_mode = 2'b01; bus.in_tag = 5'd10;
    @(posedge clk); #1;
    check("bp_first_valid", bus.out_valid, 1);
    check("bp_ready_after_first", bus.in_ready, 1);
    bus.in_imm = 16'h0F0F; bus.in_mode = 2'b10; bus.in_tag = 5'd11;
    @(posedge clk); #1;
    bus.in_imm = 16'h1111; bus.in_mode = 2'b00; bus.in_tag = 5'd12;
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready_low", bus.in_ready, 0);
      check("bp_hold_data", bus.out_data, 32'hFFFFA5A5);
      check("bp_hold_tag", bus.out_tag, 5'd10);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_second_tag", bus.out_tag, 5'd11);
    check("bp_second_data", bus.out_data, 32'h0F0F0000);
    check("bp_ready_back", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_third_valid", bus.out_valid, 1);
    check("bp_third_tag", bus.out_tag, 5'd12);
    check("bp_third_data", bus.out_data, 32'h00001111);
    @(posedge clk); #1;
    check("bp_empty", bus.out_valid, 0);

    // Reset with OR and SK full
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_imm = 16'h2222; bus.in_mode = 2'b00; bus.in_tag = 5'd20;
    @(posedge clk); #1;
    bus.in_tag = 5'd21;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("mid_full_in_ready", bus.in_ready, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_in_ready", bus.in_ready, 0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_ready_back", bus.in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      check("mid_rst_no_stale", bus.out_valid, 0);
      @(posedge clk); #1;
    end

    // IN_W=12 instance
    bus12.out_ready = 1'b1;
    check("w12_in_ready", bus12.in_ready, 1);
    bus12.in_valid = 1'b1; bus12.in_imm = 12'h800; bus12.in_mode = 2'b01; bus12.in_tag = 5'd3;
    @(posedge clk); #1;
    check("w12_sign_valid", bus12.out_valid, 1);
    check("w12_sign_data", bus12.out_data, 32'hFFFFF800);
    check("w12_sign_tag", bus12.out_tag, 5'd3);
    bus12.in_imm = 12'hABC; bus12.in_mode = 2'b10; bus12.in_tag = 5'd4;
    @(posedge clk); #1;
    bus12.in_valid = 1'b0;
    check("w12_upper_data", bus12.out_data, 32'hABC00000);
    check("w12_upper_tag", bus12.out_tag, 5'd4);
    bus12.in_imm = 12'hFFF; bus12.in_mode = 2'b11; bus12.in_valid = 1'b1;
    @(posedge clk); #1;
    bus12.in_valid = 1'b0;
    check("w12_branch_data", bus12.out_data, 32'hFFFFFFFC);
    @(posedge clk); #1;

`ifdef IMM_EXT_CNT_EN
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("cnt_reset_zero", xfer_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_imm = 16'h0042; bus.in_mode = 2'b00; bus.in_tag = 5'd9;
    repeat (32'h10001) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("cnt_wrap", xfer_cnt, 16'h0001);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("cnt_reset_again", xfer_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
`endif

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
